// File: rtl/tbox_move_ctrl.sv
// Tic-tac-toe move controller: validates a player's move request, strobes the board write
// and reports the result. Optional WAIT-state timeout via define TBOX_MOVE_TIMEOUT_EN.
module tbox_move_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] req_row,
    input  logic [1:0] req_col,
    input  logic [8:0] valid,
    input  logic [1:0] game_state,
    output logic       set,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic [3:0] move_count
);

    localparam logic [2:0] ST_OK        = 3'b000;
    localparam logic [2:0] ST_OCCUPIED  = 3'b001;
    localparam logic [2:0] ST_BAD_COORD = 3'b010;
    localparam logic [2:0] ST_GAME_OVER = 3'b011;
    localparam logic [3:0] MAX_MOVES    = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        REPORT
    } state_t;

    state_t     state;
    logic [3:0] cell_idx;

    // A zero timeout would abandon every move before the board can answer.
    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("tbox_move_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef TBOX_MOVE_TIMEOUT_EN
    localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]  ST_TIMEOUT  = 3'b100;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] wait_cnt;
`endif

    // row/col double as the captured request, so the board index follows them.
    assign cell_idx = 4'(row) * 4'd3 + 4'(col);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            set        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            status     <= ST_OK;
            move_count <= 4'd0;
            row        <= 2'd0;
            col        <= 2'd0;
`ifdef TBOX_MOVE_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            set  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid == 9'b0) begin
                        move_count <= 4'd0;
                    end
                    if (req) begin
                        row   <= req_row;
                        col   <= req_col;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (game_state != 2'b00) begin
                        status <= ST_GAME_OVER;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end else if (row == 2'd3 || col == 2'd3) begin
                        status <= ST_BAD_COORD;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end else if (valid[cell_idx]) begin
                        status <= ST_OCCUPIED;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end else begin
                        set   <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef TBOX_MOVE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (valid[cell_idx]) begin
                        status <= ST_OK;
                        done   <= 1'b1;
                        state  <= REPORT;
                        if (move_count < MAX_MOVES) begin
                            move_count <= move_count + 4'd1;
                        end
                    end
`ifdef TBOX_MOVE_TIMEOUT_EN
                    else if (wait_cnt == TMO_LAST) begin
                        status <= ST_TIMEOUT;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
`endif
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tbox_move_ctrl.sv
// Bench for tbox_move_ctrl: table of single moves plus hand sequences for busy, saturation,
// mid-move reset and the WAIT timeout; done results are checked against a scoreboard queue.
module tb_tbox_move_ctrl;

    localparam int unsigned TMO = 8;

    logic       clk;
    logic       reset;
    logic       req;
    logic [1:0] req_row;
    logic [1:0] req_col;
    logic [8:0] valid;
    logic [1:0] game_state;
    logic       set;
    logic [1:0] row;
    logic [1:0] col;
    logic       busy;
    logic       done;
    logic [2:0] status;
    logic [3:0] move_count;

    tbox_move_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_row    (req_row),
        .req_col    (req_col),
        .valid      (valid),
        .game_state (game_state),
        .set        (set),
        .row        (row),
        .col        (col),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .move_count (move_count)
    );

    typedef struct {
        logic [2:0] st;
        logic [3:0] mc;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] gs;
        logic [8:0] board;
        logic [2:0] st;
        logic [3:0] mc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   set_seen = 0;
    int   set_exp_cyc = 0;
    logic ack = 1'b1;
    logic pend = 1'b0;
    int   pend_idx = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: done pulses and set strobes observed on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (set) begin
                set_seen++;
                check_val("set_cycle", cyc, set_exp_cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_val("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("done_status", int'(status), int'(e.st));
                    check_val("done_move_count", int'(move_count), int'(e.mc));
                    check_val("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One clock; the board model commits a strobed write one edge after seeing set.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend) begin
            valid[pend_idx] = 1'b1;
            pend = 1'b0;
        end
        if (set && ack) begin
            pend     = 1'b1;
            pend_idx = int'(row) * 3 + int'(col);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 1'b1;
        req_row = 2'd2;
        req_col = 2'd1;
        tick();
        tick();
        req = 1'b0;
        pend = 1'b0;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_set", int'(set), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_status", int'(status), 0);
        check_val("rst_move_count", int'(move_count), 0);
        check_val("rst_row", int'(row), 0);
        check_val("rst_col", int'(col), 0);
        reset = 1'b0;
    endtask

    task automatic start_move(input logic [1:0] r, input logic [1:0] c, input logic [1:0] gs,
                              input logic [8:0] board, input logic ack_in, input logic push,
                              input logic [2:0] st, input logic [3:0] mc, input int lat);
        int c0;
        valid      = board;
        game_state = gs;
        ack        = ack_in;
        req_row    = r;
        req_col    = c;
        req        = 1'b1;
        set_seen   = 0;
        c0          = cyc + 1;
        set_exp_cyc = c0 + 1;
        if (push) sb.push_back('{st, mc, c0 + lat});
        tick();
        req = 1'b0;
    endtask

    task automatic finish_move(input logic [1:0] r, input logic [1:0] c, input int exp_set);
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        if (sb.size() != 0) begin
            check_val("done_timeout", 0, 1);
            sb.delete();
        end
        check_val("set_count", set_seen, exp_set);
        check_val("row_hold", int'(row), int'(r));
        check_val("col_hold", int'(col), int'(c));
    endtask

    task automatic run_move(input logic [1:0] r, input logic [1:0] c, input logic [1:0] gs,
                            input logic [8:0] board, input logic [2:0] st, input logic [3:0] mc);
        start_move(r, c, gs, board, 1'b1, 1'b1, st, mc, (st == 3'd0) ? 3 : 1);
        finish_move(r, c, (st == 3'd0) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'd1, 2'd2, 2'd0, 9'h000, 3'd0, 4'd1};
        tbl[1]  = '{2'd1, 2'd1, 2'd0, 9'h030, 3'd1, 4'd1};
        tbl[2]  = '{2'd3, 2'd0, 2'd0, 9'h030, 3'd2, 4'd1};
        tbl[3]  = '{2'd0, 2'd3, 2'd0, 9'h030, 3'd2, 4'd1};
        tbl[4]  = '{2'd0, 2'd0, 2'd1, 9'h030, 3'd3, 4'd1};
        tbl[5]  = '{2'd3, 2'd3, 2'd2, 9'h030, 3'd3, 4'd1};
        tbl[6]  = '{2'd2, 2'd2, 2'd0, 9'h030, 3'd0, 4'd2};
        tbl[7]  = '{2'd0, 2'd0, 2'd0, 9'h130, 3'd0, 4'd3};
        tbl[8]  = '{2'd1, 2'd2, 2'd0, 9'h131, 3'd1, 4'd3};
        tbl[9]  = '{2'd2, 2'd0, 2'd0, 9'h131, 3'd0, 4'd4};
        tbl[10] = '{2'd0, 2'd1, 2'd0, 9'h000, 3'd0, 4'd1};
        tbl[11] = '{2'd2, 2'd1, 2'd0, 9'h002, 3'd0, 4'd2};

        reset      = 1'b1;
        req        = 1'b0;
        req_row    = 2'd0;
        req_col    = 2'd0;
        valid      = 9'h000;
        game_state = 2'd0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            run_move(tbl[i].r, tbl[i].c, tbl[i].gs, tbl[i].board, tbl[i].st, tbl[i].mc);
        end

        // Saturation: keep the board non-empty and reuse cell 0 for eleven accepted moves.
        valid = 9'h100;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_move(2'd0, 2'd0, 2'd0, 9'h100, 3'd0, (i + 1 > 9) ? 4'd9 : 4'(i + 1));
        end

        // Requests while busy must be ignored: one set, one done, coordinates unchanged.
        start_move(2'd0, 2'd0, 2'd0, 9'h100, 1'b1, 1'b1, 3'd0, 4'd9, 3);
        req = 1'b1; req_row = 2'd2; req_col = 2'd2;
        tick();
        check_val("busy_during_move", int'(busy), 1);
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        finish_move(2'd0, 2'd0, 1);
        tick();
        check_val("idle_after_busy_req", int'(busy), 0);

        // Reset while parked in WAIT, then a normal move.
        start_move(2'd1, 2'd0, 2'd0, 9'h100, 1'b0, 1'b0, 3'd0, 4'd0, 0);
        tick();
        tick();
        tick();
        check_val("wait_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_val("wait_rst_busy", int'(busy), 0);
        check_val("wait_rst_done", int'(done), 0);
        check_val("wait_rst_move_count", int'(move_count), 0);
        check_val("wait_rst_set", int'(set), 0);
        reset = 1'b0;
        run_move(2'd1, 2'd0, 2'd0, 9'h100, 3'd0, 4'd1);

        // Board never acknowledges the write.
`ifdef TBOX_MOVE_TIMEOUT_EN
        start_move(2'd2, 2'd1, 2'd0, 9'h100, 1'b0, 1'b1, 3'd4, 4'd1, 2 + TMO);
        finish_move(2'd2, 2'd1, 1);
`else
        start_move(2'd2, 2'd1, 2'd0, 9'h100, 1'b0, 1'b0, 3'd0, 4'd0, 0);
        for (int k = 0; k < 30; k++) tick();
        check_val("no_timeout_busy", int'(busy), 1);
        check_val("no_timeout_set_count", set_seen, 1);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tbox_move_ctrl.md
TBOX_MOVE_CTRL -- requirements
Module: tbox_move_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, 8, max WAIT-state cycles before a move is abandoned (used only when the timeout feature is compiled in).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 1, player move request; sampled only while busy=0.
REQ-005 The block SHALL have ports req_row and req_col, input, 2 each, requested coordinates; legal range 0-2.
REQ-006 The block SHALL have port valid, input, 9, cell-occupied flags from the board; index = row*3+col.
REQ-007 The block SHALL have port game_state, input, 2, board result; 00 = game in progress, any other value = game over.
REQ-008 The block SHALL have port set, output, 1, one-cycle write strobe to the board.
REQ-009 The block SHALL have ports row and col, output, 2 each, board write coordinates.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port status, output, 3, result code, valid while done=1.
REQ-013 The block SHALL have port move_count, output, 4, count of accepted moves.

Function
REQ-014 The FSM SHALL have states IDLE, CHECK, ISSUE, WAIT and REPORT, all with registered outputs.
REQ-015 IDLE: req=1 SHALL capture req_row/req_col into registers; next state CHECK. Otherwise remain in IDLE.
REQ-016 CHECK SHALL evaluate the captured request in priority order:
- game_state!=00 -> status 011 (GAME_OVER).
- row==3 or col==3 -> status 010 (BAD_COORD).
- valid[idx]=1 -> status 001 (OCCUPIED).
- Any rejection: next state REPORT. Otherwise: next state ISSUE.
REQ-017 ISSUE SHALL assert set=1 for exactly one cycle with row/col equal to the captured values; next state WAIT.
REQ-018 WAIT SHALL move to REPORT with status 000 (OK) on the first cycle in which valid[idx]=1.
REQ-019 REPORT SHALL assert done=1 for one cycle; next state IDLE.
REQ-020 Latency: req sampled in cycle N SHALL give done in N+4 for OK and in N+2 for a rejection.
REQ-021 req while busy=1 SHALL be ignored; there is no queuing.
REQ-022 set SHALL be 0 outside ISSUE; row/col SHALL hold the last captured values.
REQ-023 move_count SHALL increment on each OK report and saturate at 9.
REQ-024 move_count SHALL clear to 0 when valid==9'b0 while in IDLE (board cleared externally).
REQ-025 status SHALL hold its last value between done pulses.

Reset
REQ-026 reset=1 at a clock edge SHALL force from any state, including mid-move:
- state IDLE; set, done, busy = 0.
- status = 000; move_count = 0; row/col = 0.
REQ-027 reset SHALL take priority over req in the same cycle.

Configuration
REQ-028 The timeout feature SHALL be controlled by macro TBOX_MOVE_TIMEOUT_EN.
- Defined: WAIT counts cycles; after TIMEOUT_CYCLES cycles without valid[idx]=1, next state REPORT with status 100 (TIMEOUT); move_count unchanged.
- Undefined: WAIT waits indefinitely, status 100 is never produced, and the counter logic is absent.

Verification
REQ-029 Directed scenario: empty board, req row=1 col=2 in cycle N -> set=1 in N+2 with row=1 col=2; done=1, status=000 in N+4; move_count=1.
REQ-030 Directed scenario: valid[4]=1, req row=1 col=1 -> done in N+2 with status=001; set never asserted.
REQ-031 Directed scenario: req row=3 col=0 -> status=010; game_state=01 with a free cell -> status=011; no set in either case.
REQ-032 Directed scenario: second req pulsed while busy=1 -> ignored; exactly one done observed.
REQ-033 Directed scenario: reset asserted during WAIT -> next cycle busy=0, done=0, move_count=0; a following legal req completes normally.
REQ-034 Directed scenario: TBOX_MOVE_TIMEOUT_EN defined, valid held at 0 after set -> done with status=100 exactly 8 WAIT cycles later; without the macro -> busy stays 1.
